monster_matrix_writer: RTL
==========================

MONSTER_MATRIX_WRITER -- requirements
Module: monster_matrix_writer

Interface
REQ-001 SHALL have parameter ROWS, default 8, the number of monster rows in the formation.
REQ-002 SHALL have parameter COLS, default 16, the number of monster columns.
REQ-003 SHALL have parameter CELL_SHIFT, default 5, giving log2 of the cell size in pixels (32x32 cells).
REQ-004 SHALL have port clk  in  1  system clock; all state updates on the rising edge.
REQ-005 SHALL have port resetN  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port startOfFrame  in  1  one-cycle pulse at the start of each VGA frame.
REQ-007 SHALL have port loadLevel  in  1  one-cycle pulse that refills the formation.
REQ-008 SHALL have port hitReq  in  1  collision request, held high until hitAck.
REQ-009 SHALL have port hitX  in  11  pixel X offset of the hit from the formation top-left.
REQ-010 SHALL have port hitY  in  11  pixel Y offset of the hit from the formation top-left.
REQ-011 SHALL have port hitAck  out  1  one-cycle acknowledge of hitReq.
REQ-012 SHALL have port killed  out  1  one-cycle pulse, coincident with hitAck, when a live monster was cleared.
REQ-013 SHALL have port mat  out  ROWS*COLS  alive matrix for display; bit [r*COLS+c] = 1 means monster (r,c) is alive.
REQ-014 SHALL have port aliveCount  out  8  number of live monsters, range 0..128.
REQ-015 SHALL have port allDead  out  1  level flag, high once the last monster is killed.
REQ-016 SHALL have port busy  out  1  high while a level load is in progress.

Function
REQ-017 SHALL implement states IDLE, LOAD and HIT, with a working matrix register.
REQ-018 SHALL, on loadLevel in any state, enter LOAD with row index 0 (a loadLevel during LOAD restarts the sweep).
REQ-019 SHALL, in LOAD, set working row r to all ones and increment r on each cycle; after row ROWS-1 it sets aliveCount to ROWS*COLS, clears allDead and returns to IDLE (8 cycles total).
REQ-020 SHALL drive busy = 1 exactly while in LOAD.
REQ-021 SHALL accept hitReq only in IDLE, only while hitAck is low, and only when no loadLevel is present that cycle; on acceptance it latches row = hitY>>CELL_SHIFT and col = hitX>>CELL_SHIFT and enters HIT.
REQ-022 SHALL, in HIT (one cycle), handle a cell that is in range (row<ROWS, col<COLS) and alive by clearing the bit, decrementing aliveCount and setting killed to 1 for the next cycle.
REQ-023 SHALL, in HIT, when the cell is dead or out of range, leave the matrix and count unchanged and keep killed at 0.
REQ-024 SHALL register hitAck high for exactly one cycle after HIT, then return to IDLE; latency from hitReq sampled to hitAck high is 2 cycles.
REQ-025 SHALL set allDead (registered, same cycle as killed) when a kill decrements aliveCount from 1 to 0; allDead is cleared only by reset or by completion of LOAD.
REQ-026 SHALL keep hitReq pending while in LOAD or HIT (no ack, no drop) and service it after returning to IDLE.
REQ-027 SHALL never decrement aliveCount below 0 or increment it above ROWS*COLS.

Reset
REQ-028 SHALL, on resetN low, immediately force: state IDLE, working matrix and mat all 0, aliveCount 0, allDead 0, hitAck 0, killed 0, busy 0, row index 0.
REQ-029 SHALL abandon any load or hit in progress on reset mid-operation; no pending hitAck is issued after reset is released.

Configuration
REQ-030 SHALL support macro MONSTER_MATRIX_DOUBLE_BUFFER_EN.
REQ-031 SHALL, when MONSTER_MATRIX_DOUBLE_BUFFER_EN is defined, copy the working matrix into a registered display copy on startOfFrame and drive mat from that copy, so mat changes only in the cycle after startOfFrame.
REQ-032 SHALL, when MONSTER_MATRIX_DOUBLE_BUFFER_EN is undefined, drive mat directly from the working matrix, so changes appear the cycle after the LOAD or HIT update; all other behaviour is identical.

Verification
REQ-033 SHALL cover: reset, then loadLevel pulse -> busy high for 8 cycles, then aliveCount=128, mat all ones, allDead=0.
REQ-034 SHALL cover: hitReq with hitX=70, hitY=40 -> hitAck and killed high 2 cycles later, bit [1*16+2] cleared, aliveCount=127.
REQ-035 SHALL cover: repeating the same hit -> hitAck=1, killed=0, aliveCount stays 127; hitX=600 (col 18) -> hitAck=1, killed=0, no change.
REQ-036 SHALL cover: hitReq asserted in the same cycle as loadLevel -> no ack during the 8 LOAD cycles, ack after LOAD, killed=1, aliveCount=127.
REQ-037 SHALL cover: killing all 128 monsters -> allDead rises with the 128th killed and stays high until the next LOAD completes.
REQ-038 SHALL cover, with MONSTER_MATRIX_DOUBLE_BUFFER_EN defined: a kill mid-frame -> mat unchanged until the cycle after the next startOfFrame; resetN pulsed during LOAD -> all outputs return to 0 at once.

Source files
------------

// File: rtl/monster_matrix_writer.sv
// Alive matrix for the monster formation: level load sweep, hit resolution and counters.
// Optional display double buffer: MONSTER_MATRIX_DOUBLE_BUFFER_EN.
module monster_matrix_writer #(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 16,
  parameter int unsigned CELL_SHIFT = 5
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 loadLevel,
  input  logic                 hitReq,
  input  logic [10:0]          hitX,
  input  logic [10:0]          hitY,
  output logic                 hitAck,
  output logic                 killed,
  output logic [ROWS*COLS-1:0] mat,
  output logic [7:0]           aliveCount,
  output logic                 allDead,
  output logic                 busy
);

  localparam int unsigned Cells = ROWS * COLS;
  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StHit} state_e;

  state_e            state_q, state_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [Cells-1:0]  work_q, work_d;
  logic [7:0]        count_q, count_d;
  logic              dead_q, dead_d;
  logic              ack_q, ack_d;
  logic              killed_q, killed_d;
  logic [10:0]       hit_row_q, hit_row_d;
  logic [10:0]       hit_col_q, hit_col_d;

  logic [Cells-1:0]  load_mask;
  logic [Cells-1:0]  hit_mask;
  logic              hit_alive;

  // Out-of-range coordinates simply match no cell, giving an empty mask.
  always_comb begin
    load_mask = '0;
    hit_mask  = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (row_q == RowW'(r)) load_mask[r*COLS +: COLS] = '1;
      for (int unsigned c = 0; c < COLS; c++) begin
        if (hit_row_q == 11'(r) && hit_col_q == 11'(c)) hit_mask[r*COLS + c] = 1'b1;
      end
    end
  end

  assign hit_alive = |(work_q & hit_mask);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    work_d    = work_q;
    count_d   = count_q;
    dead_d    = dead_q;
    ack_d     = 1'b0;
    killed_d  = 1'b0;
    hit_row_d = hit_row_q;
    hit_col_d = hit_col_q;
    if (loadLevel) begin
      // A load pre-empts everything; an unfinished hit stays pending on hitReq.
      state_d = StLoad;
      row_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hitReq && !ack_q) begin
            state_d   = StHit;
            hit_row_d = hitY >> CELL_SHIFT;
            hit_col_d = hitX >> CELL_SHIFT;
          end
        end
        StLoad: begin
          work_d = work_q | load_mask;
          row_d  = row_q + 1'b1;
          if (row_q == RowW'(ROWS - 1)) begin
            row_d   = '0;
            count_d = 8'(Cells);
            dead_d  = 1'b0;
            state_d = StIdle;
          end
        end
        StHit: begin
          if (hit_alive && count_q != 8'd0) begin
            work_d   = work_q & ~hit_mask;
            count_d  = count_q - 8'd1;
            killed_d = 1'b1;
            if (count_q == 8'd1) dead_d = 1'b1;
          end
          ack_d   = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= StIdle;
      row_q     <= '0;
      work_q    <= '0;
      count_q   <= '0;
      dead_q    <= 1'b0;
      ack_q     <= 1'b0;
      killed_q  <= 1'b0;
      hit_row_q <= '0;
      hit_col_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      work_q    <= work_d;
      count_q   <= count_d;
      dead_q    <= dead_d;
      ack_q     <= ack_d;
      killed_q  <= killed_d;
      hit_row_q <= hit_row_d;
      hit_col_q <= hit_col_d;
    end
  end

`ifdef MONSTER_MATRIX_DOUBLE_BUFFER_EN
  logic [Cells-1:0] disp_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      disp_q <= '0;
    end else if (startOfFrame) begin
      disp_q <= work_q;
    end
  end

  assign mat = disp_q;
`else
  logic unused_sof;
  assign unused_sof = startOfFrame;
  assign mat        = work_q;
`endif

  assign hitAck     = ack_q;
  assign killed     = killed_q;
  assign aliveCount = count_q;
  assign allDead    = dead_q;
  assign busy       = (state_q == StLoad);

endmodule
